// File: rtl/uart_recv_os_if.sv
// Receive-side bundle for uart_recv_os: serial line in, FIFO pop port and status out.
// master = receiver, slave = consumer/line driver.
interface uart_recv_os_if;
   logic       rx;
   logic [7:0] d;
   logic       valid;
   logic       ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (input rx, ack, output d, valid, frame_err, overrun, busy);
   modport slave  (output rx, ack, input d, valid, frame_err, overrun, busy);
endinterface

// File: rtl/uart_recv_os.sv
// 8N1 UART receiver with 3-sample majority vote around mid-bit and a
// first-word-fall-through receive FIFO with valid/ack pop.
//
// state | meaning
// IDLE  | waiting for a high-to-low edge on the synchronised line
// START | timing the start bit; a high majority vote rejects it as a false start
// DATA  | shifting in 8 data bits, LSB first
// STOP  | sampling the stop bit; leaves at mid-bit to push, drop or flag the byte
module uart_recv_os #(
   parameter int DIVIDER    = 868,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   uart_recv_os_if.master bus
);
   localparam int HALF = DIVIDER / 2;
   localparam int CW   = $clog2(DIVIDER);
   localparam int AW   = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] C_HALF    = CW'(HALF);
   localparam logic [CW-1:0] C_HALF_P1 = CW'(HALF + 1);
   localparam logic [CW-1:0] C_LAST    = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] C_ONE     = CW'(1);
   localparam logic [AW-1:0] P_ONE     = AW'(1);
   localparam logic [AW:0]   N_ONE     = (AW+1)'(1);
   localparam logic [AW:0]   N_DEPTH   = (AW+1)'(FIFO_DEPTH);

   if (DIVIDER < 8) begin : g_bad_divider
      $error("uart_recv_os: DIVIDER must be >= 8");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_recv_os: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_rx_m, r_rx_s, r_rx_p;
   logic [CW-1:0]   r_cnt;
   logic            r_s0, r_s1;
   logic [2:0]      r_idx;
   logic [7:0]      r_shreg;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [AW:0]     r_count;
   logic            r_ferr, r_ovr;

   logic w_maj, w_dec, w_wrap, w_valid, w_full, w_pop, w_push, w_ferr_nxt, w_ovr_nxt;

   assign w_maj   = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
   assign w_dec   = (r_cnt == C_HALF_P1);
   assign w_wrap  = (r_cnt == C_LAST);
   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == N_DEPTH);
   assign w_pop   = bus.ack & w_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
      case (r_state)
         IDLE:  if (r_rx_p && !r_rx_s) w_state_nxt = START;
         START: begin
            if (w_dec && w_maj)  w_state_nxt = IDLE;
            else if (w_wrap)     w_state_nxt = DATA;
         end
         DATA:  if (w_wrap && r_idx == 3'd7) w_state_nxt = STOP;
         STOP: begin
            if (w_dec) begin
               w_state_nxt = IDLE;
               if (!w_maj)                w_ferr_nxt = 1'b1;
               else if (!w_full || w_pop) w_push     = 1'b1;
               else                       w_ovr_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_m  <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_p  <= 1'b1;
         r_cnt   <= '0;
         r_s0    <= 1'b1;
         r_s1    <= 1'b1;
         r_idx   <= '0;
         r_shreg <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_rx_m <= bus.rx;
         r_rx_s <= r_rx_m;
         r_rx_p <= r_rx_s;
         // Holding cnt at 0 in IDLE makes START begin at cnt=0 the cycle after the edge.
         if (r_state == IDLE || w_wrap) r_cnt <= '0;
         else                           r_cnt <= r_cnt + C_ONE;
         if (r_cnt == C_HALF_M1) r_s0 <= r_rx_s;
         if (r_cnt == C_HALF)    r_s1 <= r_rx_s;
         if (r_state == START)                r_idx <= '0;
         else if (r_state == DATA && w_wrap)  r_idx <= r_idx + 3'd1;
         if (r_state == DATA && w_dec) r_shreg[r_idx] <= w_maj;
         if (w_push) r_wr <= r_wr + P_ONE;
         if (w_pop)  r_rd <= r_rd + P_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + N_ONE;
            2'b01:   r_count <= r_count - N_ONE;
            default: r_count <= r_count;
         endcase
         r_ferr <= w_ferr_nxt;
         r_ovr  <= w_ovr_nxt;
      end
   end

   // Storage needs no reset: only entries behind a valid count are ever visible.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= r_shreg;
   end

   assign bus.valid     = w_valid;
   assign bus.d         = w_valid ? r_mem[r_rd] : 8'h00;
   assign bus.frame_err = r_ferr;
   assign bus.overrun   = r_ovr;
   assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_recv_os.sv
// Self-checking bench for uart_recv_os (DIVIDER=16, FIFO_DEPTH=4): directed
// frames plus random frames checked against a queue model of the receive FIFO.
module tb_uart_recv_os;
   localparam int DIV   = 16;
   localparam int DEPTH = 4;
   localparam int HALFB = DIV / 2;
   // line edge -> 2 sync flops -> START, 9 bit periods, mid-stop decision, then IDLE
   localparam int FALL  = 2 + 1 + 9 * DIV + (HALFB + 1) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_recv_os_if bus ();

   uart_recv_os #(.DIVIDER(DIV), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] q[$];

   int   fall_cyc, ferr_cnt, ovr_cnt;
   logic busy_seen, valid_at_fall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bit_edge(input int k, input int pct);
      return (k * DIV * pct + 50) / 100;
   endfunction

   // Drives one frame; ack is high only in cycle ack_at; rst is raised mid-cycle at abort_at.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int pct,
                             input int ack_at, input int abort_at);
      logic [9:0] bits;
      int k;
      int total;
      bits = {stop, b, 1'b0};
      total = bit_edge(10, pct);
      fall_cyc = -1; ferr_cnt = 0; ovr_cnt = 0; busy_seen = 1'b0; valid_at_fall = 1'b0;
      for (int c = 0; c < total; c++) begin
         k = 0;
         while (bit_edge(k + 1, pct) <= c) k++;
         bus.rx  = bits[k];
         bus.ack = (c == ack_at);
         if (c == abort_at) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_valid", 32'(bus.valid), 32'd0);
            bus.ack = 1'b0;
            bus.rx  = 1'b1;
            return;
         end
         @(posedge clk); #1;
         if (bus.frame_err) ferr_cnt++;
         if (bus.overrun)   ovr_cnt++;
         if (bus.busy) busy_seen = 1'b1;
         else if (busy_seen && fall_cyc < 0) begin
            fall_cyc = c + 1;
            valid_at_fall = bus.valid;
         end
      end
      bus.ack = 1'b0;
      bus.rx  = 1'b1;
   endtask

   // Frame plus model update: a pop in the decision cycle frees a slot before the push.
   task automatic frame(input logic [7:0] b, input logic stop, input logic ack_dec);
      int exp_ovr;
      exp_ovr = 0;
      send_frame(b, stop, 100, ack_dec ? FALL - 1 : -1, -1);
      if (ack_dec && q.size() > 0) void'(q.pop_front());
      if (stop) begin
         if (q.size() < DEPTH) q.push_back(b);
         else exp_ovr = 1;
      end
      chk("fall_cycle", 32'(fall_cyc), 32'(FALL));
      chk("frame_err_cnt", 32'(ferr_cnt), 32'(!stop));
      chk("overrun_cnt", 32'(ovr_cnt), 32'(exp_ovr));
      chk("valid_at_fall", 32'(valid_at_fall), 32'(q.size() > 0));
      chk("d_after_frame", 32'(bus.d), 32'(q.size() > 0 ? q[0] : 8'h00));
   endtask

   task automatic pop_chk();
      chk("pop_valid", 32'(bus.valid), 32'(q.size() > 0));
      chk("pop_d", 32'(bus.d), 32'(q.size() > 0 ? q[0] : 8'h00));
      bus.ack = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic idle(input int n);
      bus.rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.rx  = 1'b1;
      bus.ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_d", 32'(bus.d), 32'h00);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      idle(4);

      // 1: single good frame, then pop
      frame(8'hA5, 1'b1, 1'b0);
      chk("t1_d", 32'(bus.d), 32'hA5);
      pop_chk();
      chk("t1_valid_after_pop", 32'(bus.valid), 32'd0);
      chk("t1_d_after_pop", 32'(bus.d), 32'h00);
      pop_chk();

      // 2: 3-cycle glitch is a false start
      busy_seen = 1'b0; ferr_cnt = 0; ovr_cnt = 0;
      begin
         int vseen;
         vseen = 0;
         for (int c = 0; c < 40; c++) begin
            bus.rx = (c < 3) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.frame_err) ferr_cnt++;
            if (bus.overrun) ovr_cnt++;
            if (bus.valid) vseen++;
         end
         chk("t2_busy_seen", 32'(busy_seen), 32'd1);
         chk("t2_busy_end", 32'(bus.busy), 32'd0);
         chk("t2_valid", 32'(vseen), 32'd0);
         chk("t2_ferr", 32'(ferr_cnt), 32'd0);
         chk("t2_ovr", 32'(ovr_cnt), 32'd0);
      end

      // 3: framing error, then a good frame
      frame(8'h3C, 1'b0, 1'b0);
      chk("t3_valid_after_err", 32'(bus.valid), 32'd0);
      idle(20);
      frame(8'h11, 1'b1, 1'b0);
      chk("t3_d", 32'(bus.d), 32'h11);
      pop_chk();

      // 4: five frames into a 4-deep FIFO
      for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_head", 32'(bus.d), 32'(i));
         pop_chk();
      end
      chk("t4_empty", 32'(bus.valid), 32'd0);

      // 5: pop in the decision cycle of the fifth frame avoids overrun
      for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, i == 5);
      for (int i = 2; i <= 5; i++) begin
         chk("t5_head", 32'(bus.d), 32'(i));
         pop_chk();
      end
      chk("t5_empty", 32'(bus.valid), 32'd0);

      // 6: async reset in data bit 4, then a slow (+3%) frame
      frame(8'h55, 1'b1, 1'b0);
      send_frame(8'h99, 1'b1, 100, -1, 5 * DIV + HALFB);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(5);
      chk("t6_valid_after_rst", 32'(bus.valid), 32'd0);
      send_frame(8'h7E, 1'b1, 103, -1, -1);
      q.push_back(8'h7E);
      chk("t6_slow_valid", 32'(bus.valid), 32'd1);
      chk("t6_slow_d", 32'(bus.d), 32'h7E);
      pop_chk();

      // random frames, stop errors, decision-cycle pops and idle pops
      for (int n = 0; n < 24; n++) begin
         logic [7:0] b;
         logic stop;
         logic ack;
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         ack  = ($urandom_range(0, 3) == 0);
         frame(b, stop, ack);
         if (!stop) idle(4);
         if ($urandom_range(0, 2) == 0) begin
            int np;
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) pop_chk();
         end
      end
      while (q.size() > 0) pop_chk();
      chk("final_empty", 32'(bus.valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
